// File: rtl/key_display_mux.sv
// Two-digit key history shown on a multiplexed seven-segment display.
// Digit slots are separated by a blanking gap to suppress ghosting.
module key_display_mux #(
  parameter int REFRESH_CYCLES = 48000,
  parameter int BLANK_CYCLES   = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key,
  input  logic       key_valid,
  output logic [6:0] seg,
  output logic [1:0] anode_n,
  output logic [7:0] digits
);

  localparam int CW          = $clog2(REFRESH_CYCLES);
  localparam int SHOW_CYCLES = REFRESH_CYCLES - BLANK_CYCLES;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [6:0]    SEG_OFF    = 7'b1111111;

  typedef enum logic [1:0] {SHOW_R, BLANK_R, SHOW_L, BLANK_L} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    left_q, left_d, right_q, right_d;
  logic          left_valid_q, left_valid_d, right_valid_q, right_valid_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    anode_q, anode_d;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    state_d       = state_q;
    cnt_d         = cnt_q + CW'(1);
    left_d        = left_q;
    right_d       = right_q;
    left_valid_d  = left_valid_q;
    right_valid_d = right_valid_q;
    seg_d         = SEG_OFF;
    anode_d       = 2'b11;

    // Every strobe cycle is a press; capture ignores the display sequencing.
    if (key_valid) begin
      left_d        = right_q;
      right_d       = key;
      left_valid_d  = right_valid_q;
      right_valid_d = 1'b1;
    end

    case (state_q)
      SHOW_R: if (cnt_q == SHOW_LAST) begin
        state_d = BLANK_R;
        cnt_d   = '0;
      end
      BLANK_R: if (cnt_q == BLANK_LAST) begin
        state_d = SHOW_L;
        cnt_d   = '0;
      end
      SHOW_L: if (cnt_q == SHOW_LAST) begin
        state_d = BLANK_L;
        cnt_d   = '0;
      end
      default: if (cnt_q == BLANK_LAST) begin
        state_d = SHOW_R;
        cnt_d   = '0;
      end
    endcase

    // Outputs are a registered decode of the current state and digits.
    case (state_q)
      SHOW_R: begin
        anode_d = 2'b10;
        if (right_valid_q) seg_d = hex7(right_q);
      end
      SHOW_L: begin
        anode_d = 2'b01;
        if (left_valid_q) seg_d = hex7(left_q);
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SHOW_R;
      cnt_q         <= '0;
      left_q        <= '0;
      right_q       <= '0;
      left_valid_q  <= 1'b0;
      right_valid_q <= 1'b0;
      seg_q         <= SEG_OFF;
      anode_q       <= 2'b11;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      left_q        <= left_d;
      right_q       <= right_d;
      left_valid_q  <= left_valid_d;
      right_valid_q <= right_valid_d;
      seg_q         <= seg_d;
      anode_q       <= anode_d;
    end
  end

  assign seg     = seg_q;
  assign anode_n = anode_q;
  assign digits  = {left_q, right_q};

endmodule

// File: tb/tb_key_display_mux.sv
// Directed bench for key_display_mux with REFRESH_CYCLES=8, BLANK_CYCLES=2.
// Expected anode pattern per 16-edge period: 6x10, 2x11, 6x01, 2x11.
module tb_key_display_mux;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key;
  logic       key_valid;
  logic [6:0] seg;
  logic [1:0] anode_n;
  logic [7:0] digits;

  int n_tests = 0;
  int n_fail  = 0;
  int n       = 0;  // edges since last reset release

  key_display_mux #(.REFRESH_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .key(key), .key_valid(key_valid),
    .seg(seg), .anode_n(anode_n), .digits(digits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, n);
    end
  endtask

  function automatic logic [1:0] exp_anode(input int e);
    int p;
    p = (e - 1) % 16;
    if (p < 6)       return 2'b10;
    else if (p < 8)  return 2'b11;
    else if (p < 14) return 2'b01;
    else             return 2'b11;
  endfunction

  // One clock edge, then check anode pattern and optionally slot contents.
  task automatic step(input bit do_seg, input logic [6:0] r, input logic [6:0] l);
    logic [1:0] ea;
    @(posedge clk);
    #1;
    n++;
    ea = exp_anode(n);
    check("anode_n", {6'd0, anode_n}, {6'd0, ea});
    if (do_seg) begin
      if (ea == 2'b10)      check("seg_right", {1'b0, seg}, {1'b0, r});
      else if (ea == 2'b01) check("seg_left",  {1'b0, seg}, {1'b0, l});
      else                  check("seg_blank", {1'b0, seg}, 8'h7F);
    end
  endtask

  initial begin
    reset = 1'b1;
    key = 4'h0;
    key_valid = 1'b0;
    #3;
    check("rst_seg",    {1'b0, seg}, 8'h7F);
    check("rst_anode",  {6'd0, anode_n}, 8'h03);
    check("rst_digits", digits, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    n = 0;

    // Idle: blank display, empty history.
    for (int i = 0; i < 32; i++) step(1'b1, 7'h7F, 7'h7F);
    check("idle_digits", digits, 8'h00);

    // Single key 1: right digit lit, left still invalid.
    key_valid = 1'b1; key = 4'h1;
    step(1'b0, 7'h7F, 7'h7F);
    key_valid = 1'b0;
    check("one_digits", digits, 8'h01);
    for (int i = 0; i < 16; i++) step(1'b1, 7'b1111001, 7'h7F);

    // A then 3, five cycles apart.
    key_valid = 1'b1; key = 4'hA;
    step(1'b0, 7'h7F, 7'h7F);
    key_valid = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 7'h7F, 7'h7F);
    key_valid = 1'b1; key = 4'h3;
    step(1'b0, 7'h7F, 7'h7F);
    key_valid = 1'b0;
    check("a3_digits", digits, 8'hA3);
    for (int i = 0; i < 16; i++) step(1'b1, 7'b0110000, 7'b0001000);

    // Strobe held three cycles: three shifts.
    key_valid = 1'b1; key = 4'h7;
    step(1'b0, 7'h7F, 7'h7F);
    check("hold_e1", digits, 8'h37);
    step(1'b0, 7'h7F, 7'h7F);
    check("hold_e2", digits, 8'h77);
    step(1'b0, 7'h7F, 7'h7F);
    check("hold_e3", digits, 8'h77);
    key_valid = 1'b0;
    for (int i = 0; i < 16; i++) step(1'b1, 7'b1111000, 7'b1111000);

    // Strobe on the SHOW_R->BLANK_R edge (edge index 6 mod 16).
    while ((n + 1) % 16 != 6) step(1'b0, 7'h7F, 7'h7F);
    key_valid = 1'b1; key = 4'h5;
    step(1'b0, 7'h7F, 7'h7F);
    key_valid = 1'b0;
    check("edge_digits", digits, 8'h75);
    for (int i = 0; i < 16; i++) step(1'b1, 7'b0010010, 7'b1111000);

    // Load F0, then reset asynchronously in the middle of SHOW_L.
    key_valid = 1'b1; key = 4'hF;
    step(1'b0, 7'h7F, 7'h7F);
    key = 4'h0;
    step(1'b0, 7'h7F, 7'h7F);
    key_valid = 1'b0;
    check("f0_digits", digits, 8'hF0);
    while (n % 16 != 11) step(1'b1, 7'b1000000, 7'b0001110);
    #2;
    reset = 1'b1;
    #1;
    check("arst_seg",    {1'b0, seg}, 8'h7F);
    check("arst_anode",  {6'd0, anode_n}, 8'h03);
    check("arst_digits", digits, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 7'h7F, 7'h7F);
    check("post_digits", digits, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_display_mux.md
Name: key_display_mux

Overview:
- Consumes the one-cycle key strobe and 4-bit hex code produced by the keypad decoder.
- Keeps a two-digit history: the newest key is the right digit and the previous key is the left digit.
- Time-multiplexes both digits onto one shared seven-segment bus with per-digit active-low anode enables.
- Inserts a blanking gap between digit switches to suppress ghosting.

Parameters:
- REFRESH_CYCLES, 48000, total clk cycles each digit slot lasts (show + blank); must exceed BLANK_CYCLES.
- BLANK_CYCLES, 480, clk cycles at the end of each slot with both anodes off; must be ≥1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- key  input  4  hex key code from the keypad decoder.
- key_valid  input  1  one-cycle strobe; key is captured when high.
- seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low (0 = lit), registered.
- anode_n  output  2  digit enables {left,right}, active-low, registered.
- digits  output  8  {left_digit,right_digit} history, registered, for debug/verification.

Behaviour:
- Reset is asynchronous and active-high. While reset=1 and afterwards until the first clock:
  - seg=7'b1111111 and anode_n=2'b11.
  - digits=8'h00; both digit-valid flags are 0.
  - The FSM is in SHOW_R and the slot counter is 0.
  - Reset asserted mid-operation clears everything immediately, regardless of FSM state.
- Capture:
  - Every rising edge with key_valid=1 does left_digit<=right_digit, right_digit<=key, left_valid<=right_valid, right_valid<=1.
  - There is no edge detection. Each high cycle is one press, so 3 consecutive high cycles shift 3 times.
  - Capture is independent of FSM state and counter. It is visible on digits the next cycle.
- FSM states: SHOW_R, BLANK_R, SHOW_L, BLANK_L, cycling in that order forever. The counter resets to 0 on every state change.
  - SHOW_R→BLANK_R and SHOW_L→BLANK_L after REFRESH_CYCLES−BLANK_CYCLES cycles in the state.
  - BLANK_R→SHOW_L and BLANK_L→SHOW_R after BLANK_CYCLES cycles in the state.
  - Full period is 2*REFRESH_CYCLES cycles.
  - The counter width is $clog2(REFRESH_CYCLES). The counter never wraps mid-state.
- Output register, 1-cycle latency from state and digit registers:
  - In SHOW_R: anode_n=2'b10; seg=hex(right_digit) if right_valid, else 7'b1111111.
  - In SHOW_L: anode_n=2'b01; seg=hex(left_digit) if left_valid, else 7'b1111111.
  - In BLANK_x: anode_n=2'b11 and seg=7'b1111111.
  - A key captured during SHOW_x shows its new value on seg 2 cycles after the strobe edge: 1 cycle to the digit register, 1 cycle to the output register.
- Hex encoding (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Invariant: anode_n is never 2'b00 in any cycle.

Test Plan:
- Set REFRESH_CYCLES=8, BLANK_CYCLES=2 for all scenarios.
- Reset, then idle 32 cycles:
  - anode_n sequence per 16-cycle period is 6×10, 2×11, 6×01, 2×11, offset 1 cycle from the FSM.
  - seg=7'h7F throughout; digits=8'h00.
- One strobe, key=4'h1:
  - digits=8'h01.
  - seg=1111001 whenever anode_n=10.
  - seg=1111111 whenever anode_n=01 (left digit not yet valid).
- Strobes key=4'hA then key=4'h3, 5 cycles apart:
  - digits=8'hA3.
  - Right slot shows 0110000; left slot shows 0001000.
- key_valid held high 3 cycles with key=4'h7:
  - digits=8'h77 after the 2nd edge and stays 8'h77 after the 3rd.
  - Both slots show 1111000.
- Strobe coincident with the SHOW_R→BLANK_R transition edge:
  - The capture is not lost.
  - BLANK timing is unchanged (still 2 cycles).
  - The new digit appears in the next SHOW_R slot.
- Assert reset asynchronously mid-SHOW_L with digits=8'hF0:
  - seg=7'h7F, anode_n=11 and digits=00 before the next clk edge.
  - After release, the FSM restarts at SHOW_R with a full 6-cycle show.
